// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   FETCH_XLEN    : width of the instruction and PC fields in a queue entry
//   NOP_INST      : word returned for reads past the end of instruction memory
//   fetch_entry_t : {inst, pc} pair carried through the fetch queue
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;

  localparam logic [FETCH_XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] inst;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_q2.sv
// Two-entry FIFO of fetch_entry_t.
//   clk, rst    : clock, synchronous active-high reset (clears storage)
//   flush       : drop all entries (storage contents left as-is)
//   push, data  : enqueue push_data at the tail
//   pop         : dequeue the head
//   head        : current head entry
//   count       : number of valid entries (0..2)
// The caller never pushes when full or pops when empty.
module fetch_q2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/imem_fetch_q.sv
// Instruction-fetch stage: owns the PC, reads a word-addressed instruction memory with one
// cycle of registered latency, and hands {inst, pc} pairs to decode over valid/ready through a
// 2-entry queue. Redirect flushes the queue and the in-flight read.
//   clk, rst           : clock, synchronous active-high reset
//   imem_we/waddr/wdata: memory load port (byte address, bits [1:0] ignored)
//   fetch_en           : allow new fetches
//   redirect_valid/pc  : PC redirect (highest priority)
//   inst_valid/ready   : handshake to decode
//   inst_out, pc_out   : instruction word and its PC
//   fetch_fault        : sticky misaligned-redirect flag, only with FETCH_MISALIGN_CHK_EN
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirect check).
// XLEN must equal fetch_pkg::FETCH_XLEN.
module imem_fetch_q
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 256,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_we,
  input  logic [XLEN-1:0] imem_waddr,
  input  logic [XLEN-1:0] imem_wdata,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] pc_out
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic            fetch_fault
`endif
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];

  logic [XLEN-1:0] pc_q;
  logic            inflight_q;
  logic [XLEN-1:0] rd_data_q, rd_pc_q;

  logic [AW-1:0]   ridx, widx;
  logic            ridx_ok, widx_ok;
  logic [XLEN-1:0] redirect_target;
  logic            fault_blk;
  logic            issue;
  logic [1:0]      occ;

  fetch_entry_t    q_push_data, q_head;
  logic            q_push, q_pop, q_empty;
  logic [1:0]      q_count;

  assign ridx    = pc_q[AW+1:2];
  assign widx    = imem_waddr[AW+1:2];
  // Only matters when DEPTH is not a power of two.
  assign ridx_ok = {1'b0, ridx} < DEPTH_W;
  assign widx_ok = {1'b0, widx} < DEPTH_W;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q;
  logic unused_waddr;

  assign redirect_target = redirect_pc;
  assign fault_blk       = fault_q;
  assign fetch_fault     = fault_q;
  assign unused_waddr    = ^{imem_waddr[XLEN-1:AW+2], imem_waddr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q <= |redirect_pc[1:0];
    end
  end
`else
  logic unused_bits;

  // Low bits are dropped so a misaligned target behaves as its aligned word.
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign fault_blk       = 1'b0;
  assign unused_bits     = ^{imem_waddr[XLEN-1:AW+2], imem_waddr[1:0], redirect_pc[1:0]};
`endif

  // The in-flight word is counted against queue capacity so it always has a slot.
  assign occ     = q_count + {1'b0, inflight_q};
  assign issue   = fetch_en && !redirect_valid && !fault_blk && (occ < 2'd2);

  assign q_empty = (q_count == 2'd0);
  // With an empty queue the in-flight word is presented directly; it is only buffered if
  // decode does not take it this cycle.
  assign q_pop   = !q_empty && inst_ready;
  assign q_push  = inflight_q && !redirect_valid && !(q_empty && inst_ready);

  assign q_push_data.inst = rd_data_q;
  assign q_push_data.pc   = rd_pc_q;

  fetch_q2 u_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  // Memory and read register are not reset; inflight_q qualifies the read data.
  always_ff @(posedge clk) begin
    if (imem_we && widx_ok) begin
      mem[widx] <= imem_wdata;
    end
    if (issue) begin
      rd_data_q <= ridx_ok ? mem[ridx] : NOP_INST;
      rd_pc_q   <= pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (redirect_valid) begin
        pc_q <= redirect_target;
      end else if (issue) begin
        pc_q <= pc_q + XLEN'(4);
      end
    end
  end

  always_comb begin
    inst_valid = !q_empty || inflight_q;
    inst_out   = '0;
    pc_out     = '0;
    if (!q_empty) begin
      inst_out = q_head.inst;
      pc_out   = q_head.pc;
    end else if (inflight_q) begin
      inst_out = rd_data_q;
      pc_out   = rd_pc_q;
    end
  end

endmodule

// File: tb/tb_imem_fetch_q.sv
module tb_imem_fetch_q;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_we;
  logic [31:0] imem_waddr, imem_wdata;
  logic        fetch_en, redirect_valid, inst_ready;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_valid2;
  logic [31:0] inst_out, pc_out, inst_out2, pc_out2;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_fault, fetch_fault2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_fetch_q #(.XLEN(32), .DEPTH(256), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .pc_out         (pc_out)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  // Small memory starting past its end: 0x18/0x1C read NOP, 0x20 wraps to word 0.
  imem_fetch_q #(.XLEN(32), .DEPTH(6), .RESET_PC(32'h18)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .imem_we        (imem_we && (imem_waddr < 32'h10)),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid2),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out2),
    .pc_out         (pc_out2)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_fault    (fetch_fault2)
`endif
  );

  typedef struct {
    int          rdy, fen, rv;
    logic [31:0] rpc;
    int          we;
    logic [31:0] wa, wd;
    int          ev;
    logic [31:0] ei, ep;
    int          c2;
    logic [31:0] e2i, e2p;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic add(input int rdy, input int fen, input int rv, input logic [31:0] rpc,
                     input int we, input logic [31:0] wa, input logic [31:0] wd,
                     input int ev, input logic [31:0] ei, input logic [31:0] ep,
                     input int c2, input logic [31:0] e2i, input logic [31:0] e2p);
    vec_t v;
    v.rdy = rdy; v.fen = fen; v.rv = rv; v.rpc = rpc;
    v.we = we; v.wa = wa; v.wd = wd;
    v.ev = ev; v.ei = ei; v.ep = ep;
    v.c2 = c2; v.e2i = e2i; v.e2p = e2p;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    //  rdy fen rv rpc     we wa     wd      ev inst    pc      c2 inst2   pc2
    add(1, 1, 0, 'h0,  0, 'h0, 'h0,  0, 'h0,  'h0,  0, 'h0,  'h0);   // c0 issue
    add(1, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h11, 'h0,  1, 'h13, 'h18);  // c1
    add(1, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h22, 'h4,  1, 'h13, 'h1C);
    add(1, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h33, 'h8,  1, 'h11, 'h20);
    add(1, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h44, 'hC,  1, 'h22, 'h24);
    add(0, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h55, 'h10, 0, 'h0,  'h0);   // c5 stall
    add(0, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h55, 'h10, 0, 'h0,  'h0);
    add(0, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h55, 'h10, 0, 'h0,  'h0);
    add(0, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h55, 'h10, 0, 'h0,  'h0);
    add(1, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h55, 'h10, 0, 'h0,  'h0);   // c9 release
    add(1, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h66, 'h14, 0, 'h0,  'h0);
    add(0, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'h77, 'h18, 0, 'h0,  'h0);   // c11 buffer
    add(0, 1, 1, 'h20, 0, 'h0, 'h0,  1, 'h77, 'h18, 0, 'h0,  'h0);   // c12 redirect
    add(1, 1, 0, 'h0,  0, 'h0, 'h0,  0, 'h0,  'h0,  0, 'h0,  'h0);
    add(1, 1, 0, 'h0,  0, 'h0, 'h0,  1, 'hAB, 'h20, 0, 'h0,  'h0);
    add(1, 1, 1, 'h8,  0, 'h0, 'h0,  1, 'h99, 'h24, 0, 'h0,  'h0);   // c15 redirect
    add(1, 1, 0, 'h0,  1, 'h8, 'hCC, 0, 'h0,  'h0,  0, 'h0,  'h0);   // c16 write+read idx 2
    add(1, 1, 1, 'h8,  0, 'h0, 'h0,  1, 'h33, 'h8,  0, 'h0,  'h0);   // old word
    add(1, 1, 0, 'h0,  0, 'h0, 'h0,  0, 'h0,  'h0,  0, 'h0,  'h0);
    add(1, 0, 0, 'h0,  0, 'h0, 'h0,  1, 'hCC, 'h8,  0, 'h0,  'h0);   // new word, fetch off
    add(1, 0, 0, 'h0,  0, 'h0, 'h0,  0, 'h0,  'h0,  0, 'h0,  'h0);
    add(1, 0, 0, 'h0,  0, 'h0, 'h0,  0, 'h0,  'h0,  0, 'h0,  'h0);

    tick();
    wr('h00, 'h11); wr('h04, 'h22); wr('h08, 'h33); wr('h0C, 'h44);
    wr('h10, 'h55); wr('h14, 'h66); wr('h18, 'h77); wr('h1C, 'h88);
    wr('h20, 'hAB); wr('h24, 'h99); wr('h40, 'h5A);

    chk("reset valid", 32'(inst_valid), 32'h0);
    chk("reset inst", inst_out, 32'h0);
    chk("reset pc", pc_out, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("reset fault", 32'(fetch_fault), 32'h0);
`endif

    rst = 1'b0;
    foreach (vecs[i]) begin
      inst_ready     = (vecs[i].rdy != 0);
      fetch_en       = (vecs[i].fen != 0);
      redirect_valid = (vecs[i].rv != 0);
      redirect_pc    = vecs[i].rpc;
      imem_we        = (vecs[i].we != 0);
      imem_waddr     = vecs[i].wa;
      imem_wdata     = vecs[i].wd;
      chk($sformatf("v%0d valid", i), 32'(inst_valid), 32'(vecs[i].ev));
      if (vecs[i].ev != 0) begin
        chk($sformatf("v%0d inst", i), inst_out, vecs[i].ei);
        chk($sformatf("v%0d pc", i), pc_out, vecs[i].ep);
      end
      if (vecs[i].c2 != 0) begin
        chk($sformatf("v%0d valid2", i), 32'(inst_valid2), 32'h1);
        chk($sformatf("v%0d inst2", i), inst_out2, vecs[i].e2i);
        chk($sformatf("v%0d pc2", i), pc_out2, vecs[i].e2p);
      end
      tick();
    end
    imem_we = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("fault set", 32'(fetch_fault), 32'h1);
    chk("fault valid", 32'(inst_valid), 32'h0);
    tick();
    chk("fault hold", 32'(fetch_fault), 32'h1);
    chk("fault blocked", 32'(inst_valid), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("fault clear", 32'(fetch_fault), 32'h0);
    chk("clear valid", 32'(inst_valid), 32'h0);
    tick();
    chk("resume valid", 32'(inst_valid), 32'h1);
    chk("resume inst", inst_out, 32'h5A);
    chk("resume pc", pc_out, 32'h40);
`else
    chk("misalign valid", 32'(inst_valid), 32'h0);
    tick();
    chk("aligned valid", 32'(inst_valid), 32'h1);
    chk("aligned inst", inst_out, 32'hAB);
    chk("aligned pc", pc_out, 32'h20);
`endif

    // Reset while streaming.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst valid", 32'(inst_valid), 32'h0);
    chk("midrst inst", inst_out, 32'h0);
    chk("midrst pc", pc_out, 32'h0);
    tick();
    chk("restart valid", 32'(inst_valid), 32'h1);
    chk("restart inst", inst_out, 32'h11);
    chk("restart pc", pc_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
